rr_arb_dec8: RTL

- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Holds the winner as a 3-bit index and drives a one-hot grant through a registered 3-to-8 decode.
- Sits in front of any resource currently selected by an enabled 3:8 decoder.
- Replaces static index selection with fair, hold-until-release sequencing.

---
 rtl/rr_arb_dec8.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rr_arb_dec8.sv
// rr_arb_dec8: 8-way round-robin arbiter with registered one-hot grant.
// Optional grant-hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arb_dec8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
        $error("rr_arb_dec8: TIMEOUT must be in 2..256");
    end

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       vld_q, vld_d;

    logic [2:0] win_idx;
    logic [2:0] scan_idx;
    logic       win_found;
    logic       hold;
    logic       tmo_hit;

    assign hold = en & req[idx_q];

    // Rotating priority scan: first set request at or after ptr.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        scan_idx  = ptr_q;
        for (int k = 0; k < 8; k++) begin
            scan_idx = ptr_q + 3'(k);
            if (!win_found && req[scan_idx]) begin
                win_idx   = scan_idx;
                win_found = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;

    // Hold counter restarts at zero on every entry into GRANT.
    always_comb begin
        cnt_d   = (state_q == GRANT) ? cnt_q + 8'd1 : 8'd0;
        tmo_hit = (cnt_q == TMO_LAST);
        tmo_d   = (state_q == GRANT) && hold && tmo_hit;
    end

    // Timeout bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo     = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                gnt_d = 8'h00;
                vld_d = 1'b0;
                if (en && win_found) begin
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    gnt_d   = 8'h01 << win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!hold || tmo_hit) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    gnt_d   = 8'h00;
                    ptr_d   = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;

endmodule
